bytecode_byte_unpacker: RTL

- Downstream neighbour of the PC-driven instruction-word fetcher.
- Accepts 32-bit instruction words with their word address. Buffers them in a small word FIFO.
- Emits JVM bytecode one byte per cycle, big-endian, with the byte address attached, to the decode/translate stage.
- Supports redirect (branch/jump) to an arbitrary byte address. Redirect flushes buffered words and skips the leading bytes of the first new word.

---
 rtl/bytecode_byte_unpacker_if.sv | 35 +++
 rtl/bytecode_byte_unpacker.sv | 117 +++++++++++
 2 files changed

// File: rtl/bytecode_byte_unpacker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bytecode_byte_unpacker_if                                                  |
// | Word-in / byte-out bundle between fetcher, unpacker and decode stage.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface bytecode_byte_unpacker_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]              word_in;
  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic                     word_valid;
  logic                     word_ready;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] redirect_addr;
  logic [7:0]               byte_out;
  logic [ADDRESS_WIDTH-1:0] byte_addr;
  logic                     byte_valid;
  logic                     byte_ready;
  logic [CNT_W-1:0]         fifo_count;

  modport master (
    output word_in, word_addr, word_valid, redirect, redirect_addr, byte_ready,
    input  word_ready, byte_out, byte_addr, byte_valid, fifo_count
  );

  modport slave (
    input  word_in, word_addr, word_valid, redirect, redirect_addr, byte_ready,
    output word_ready, byte_out, byte_addr, byte_valid, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/bytecode_byte_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bytecode_byte_unpacker                                                     |
// | Buffers 32-bit instruction words, emits big-endian bytecode bytes.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bytecode_byte_unpacker #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 2
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  bytecode_byte_unpacker_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]              word_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  logic [1:0]               index;
  logic [1:0]               skip;
  logic                     skip_pending;

  logic                     word_ready_c;
  logic                     byte_valid_c;
  logic                     push;
  logic                     byte_take;
  logic                     pop;
  logic [31:0]              head_word;
  logic [7:0]               head_byte;
  logic                     unused_redirect_hi;

  assign word_ready_c = !reset && !bus.redirect && (count < CNT_W'(DEPTH));
  assign byte_valid_c = (count != '0);
  assign push         = bus.word_valid && word_ready_c;
  // A byte taken during a redirect cycle is voided along with the FIFO contents.
  assign byte_take    = byte_valid_c && bus.byte_ready && !bus.redirect;
  assign pop          = byte_take && (index == 2'd3);

  assign head_word = word_mem[rd_ptr];

  always_comb begin
    head_byte = head_word[31:24];
    case (index)
      2'd0: head_byte = head_word[31:24];
      2'd1: head_byte = head_word[23:16];
      2'd2: head_byte = head_word[15:8];
      2'd3: head_byte = head_word[7:0];
      default: head_byte = head_word[31:24];
    endcase
  end

  assign bus.word_ready = word_ready_c;
  assign bus.byte_valid = byte_valid_c;
  assign bus.byte_out   = head_byte;
  assign bus.byte_addr  = addr_mem[rd_ptr] + ADDRESS_WIDTH'(index);
  assign bus.fifo_count = count;

  // Only the byte lane of the redirect target matters here; the fetcher
  // supplies the aligned word.
  assign unused_redirect_hi = ^bus.redirect_addr[ADDRESS_WIDTH-1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      index        <= 2'd0;
      skip         <= 2'd0;
      skip_pending <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (bus.redirect) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      index        <= 2'd0;
      skip         <= bus.redirect_addr[1:0];
      skip_pending <= 1'b1;
    end else begin
      if (push) begin
        word_mem[wr_ptr] <= bus.word_in;
        addr_mem[wr_ptr] <= bus.word_addr;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // The first word after a redirect lands in an empty FIFO and becomes
      // the head, so it can start straight at the skipped-to byte.
      if (push && skip_pending) begin
        index        <= skip;
        skip_pending <= 1'b0;
      end else if (byte_take) begin
        if (index == 2'd3) begin
          index <= skip_pending ? skip : 2'd0;
        end else begin
          index <= index + 2'd1;
        end
      end
    end
  end
endmodule
`default_nettype wire
